// File: rtl/exec_unit_mc.sv
// exec_unit_mc: multi-cycle RV32I execute core, private regfile + dmem.
// Define EXEC_MUL_EN to add the iterative shift-add MUL instruction.
module exec_unit_mc #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int DMEM_WORDS = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic            result_valid,
  output logic [XLEN-1:0] result_data,
  output logic [4:0]      result_rd,
  output logic            result_wb,
  output logic            illegal,
  output logic            halted
);
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(XLEN);
  localparam int AB = $clog2(XLEN / 8);
  localparam int DW = $clog2(DMEM_WORDS);
  localparam logic [2:0] MEMF3 = (XLEN == 64) ? 3'b011 : 3'b010;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MEM, S_WB, S_HALT
`ifdef EXEC_MUL_EN
    , S_MUL
`endif
  } state_e;

  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_SLT,
    A_SLTU, A_SLL, A_SRL, A_SRA, A_LUI
  } aop_e;

  state_e state_q, state_d;

  logic [31:0]     instr_q;
  logic [XLEN-1:0] data_q;
  logic [4:0]      rd_q;
  logic            wb_q;
  logic            ill_q;
  logic            hpulse_q;
  logic [DW-1:0]   widx_q;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] dmem_q [DMEM_WORDS];

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;

  assign opc = instr_q[6:0];
  assign rd  = instr_q[11:7];
  assign f3  = instr_q[14:12];
  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];
  assign f7  = instr_q[31:25];

  logic is_alu, is_load, is_store, is_sys, is_mul;
  logic use_rs1, use_rs2, use_rd, use_imm;
  logic shf_lo, shf_ar, rng_bad, mis, ill_now;
  aop_e aop;

  logic [XLEN-1:0] a, b, imm_i, imm_s, imm_u;
  logic [XLEN-1:0] opb, addr, alu;
  logic [DW-1:0]   widx;
  logic            unused_addr;

  assign a = (rs1 == 5'd0) ? '0 : regs_q[rs1[RW-1:0]];
  assign b = (rs2 == 5'd0) ? '0 : regs_q[rs2[RW-1:0]];

  assign imm_i = XLEN'($signed(instr_q[31:20]));
  assign imm_s = XLEN'($signed({instr_q[31:25], instr_q[11:7]}));
  assign imm_u = XLEN'($signed({instr_q[31:12], 12'b0}));

  // Shift-immediate upper bits must be all zero (logical) or 0100000 (arith).
  assign shf_lo = (XLEN == 64) ? (instr_q[31:26] == 6'b000000)
                               : (instr_q[31:25] == 7'b0000000);
  assign shf_ar = (XLEN == 64) ? (instr_q[31:26] == 6'b010000)
                               : (instr_q[31:25] == 7'b0100000);

  assign opb  = use_imm ? imm_i : b;
  assign addr = a + (is_store ? imm_s : imm_i);
  assign widx = addr[AB +: DW];
  assign mis  = |addr[AB-1:0];
  assign unused_addr = ^addr;

  // Decode the held instruction into a class, ALU op and operand usage.
  always_comb begin
    aop      = A_ADD;
    is_alu   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_sys   = 1'b0;
    is_mul   = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    use_imm  = 1'b0;
    unique case (opc)
      OP_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        if (f7 == 7'b0000000) begin
          is_alu = 1'b1;
          unique case (f3)
            3'b000: aop = A_ADD;
            3'b001: aop = A_SLL;
            3'b010: aop = A_SLT;
            3'b011: aop = A_SLTU;
            3'b100: aop = A_XOR;
            3'b101: aop = A_SRL;
            3'b110: aop = A_OR;
            3'b111: aop = A_AND;
          endcase
        end else if (f7 == 7'b0100000 &&
                     (f3 == 3'b000 || f3 == 3'b101)) begin
          is_alu = 1'b1;
          aop    = f3[2] ? A_SRA : A_SUB;
        end
`ifdef EXEC_MUL_EN
        else if (f7 == 7'b0000001 && f3 == 3'b000) begin
          is_mul = 1'b1;
        end
`endif
      end
      OP_I: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        use_imm = 1'b1;
        unique case (f3)
          3'b000: begin is_alu = 1'b1; aop = A_ADD; end
          3'b010: begin is_alu = 1'b1; aop = A_SLT; end
          3'b100: begin is_alu = 1'b1; aop = A_XOR; end
          3'b110: begin is_alu = 1'b1; aop = A_OR;  end
          3'b111: begin is_alu = 1'b1; aop = A_AND; end
          3'b001: begin is_alu = shf_lo; aop = A_SLL; end
          3'b101: begin
            is_alu = shf_lo | shf_ar;
            aop    = shf_ar ? A_SRA : A_SRL;
          end
          default: ;
        endcase
      end
      OP_LUI: begin
        use_rd = 1'b1;
        is_alu = 1'b1;
        aop    = A_LUI;
      end
      OP_LD: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        is_load = (f3 == MEMF3);
      end
      OP_ST: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        is_store = (f3 == MEMF3);
      end
      OP_SYS: begin
        is_sys = (instr_q == 32'h0000_0073) ||
                 (instr_q == 32'h0010_0073);
      end
      default: ;
    endcase
  end

  assign rng_bad = (use_rd  && ({1'b0, rd}  >= 6'(NREGS))) ||
                   (use_rs1 && ({1'b0, rs1} >= 6'(NREGS))) ||
                   (use_rs2 && ({1'b0, rs2} >= 6'(NREGS)));

  assign ill_now = !(is_alu | is_load | is_store | is_sys | is_mul) ||
                   rng_bad || ((is_load | is_store) && mis);

  // Single-cycle ALU used in EXEC.
  always_comb begin
    unique case (aop)
      A_ADD:   alu = a + opb;
      A_SUB:   alu = a - opb;
      A_AND:   alu = a & opb;
      A_OR:    alu = a | opb;
      A_XOR:   alu = a ^ opb;
      A_SLT:   alu = XLEN'($signed(a) < $signed(opb));
      A_SLTU:  alu = XLEN'(a < opb);
      A_SLL:   alu = a << opb[SW-1:0];
      A_SRL:   alu = a >> opb[SW-1:0];
      A_SRA:   alu = XLEN'($signed(a) >>> opb[SW-1:0]);
      A_LUI:   alu = imm_u;
      default: alu = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  logic [XLEN-1:0] mcand_q, mplier_q, prod_q, prod_nx;
  logic [SW-1:0]   cnt_q;

  assign prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);

  // Shift-add multiplier: one multiplier bit per MUL cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (state_q == S_EXEC) begin
      mcand_q  <= a;
      mplier_q <= b;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (state_q == S_MUL) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      prod_q   <= prod_nx;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (instr_valid) state_d = S_EXEC;
      S_EXEC: begin
        if (ill_now)      state_d = S_WB;
        else if (is_sys)  state_d = S_HALT;
        else if (is_load) state_d = S_MEM;
`ifdef EXEC_MUL_EN
        else if (is_mul)  state_d = S_MUL;
`endif
        else              state_d = S_WB;
      end
      S_MEM:  state_d = S_WB;
`ifdef EXEC_MUL_EN
      S_MUL:  if (cnt_q == SW'(XLEN - 1)) state_d = S_WB;
`endif
      S_WB:   state_d = S_IDLE;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and the retirement registers.
  always_comb begin
    instr_ready  = (state_q == S_IDLE);
    result_valid = (state_q == S_WB) | hpulse_q;
    illegal      = (state_q == S_WB) & ill_q;
    halted       = (state_q == S_HALT);
    result_data  = data_q;
    result_rd    = rd_q;
    result_wb    = (state_q == S_WB) & wb_q;
  end

  // Capture instruction and build the retirement record.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= '0;
      data_q   <= '0;
      rd_q     <= '0;
      wb_q     <= 1'b0;
      ill_q    <= 1'b0;
      hpulse_q <= 1'b0;
      widx_q   <= '0;
    end else begin
      hpulse_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (instr_valid) instr_q <= instr;
        S_EXEC: begin
          ill_q    <= ill_now;
          rd_q     <= (is_store | is_sys) ? 5'd0 : rd;
          wb_q     <= !ill_now && (is_alu | is_load | is_mul) &&
                      (rd != 5'd0);
          data_q   <= (ill_now | is_sys) ? '0 :
                      is_store ? addr : alu;
          widx_q   <= widx;
          hpulse_q <= is_sys & ~ill_now;
        end
        S_MEM: data_q <= dmem_q[widx_q];
`ifdef EXEC_MUL_EN
        S_MUL: data_q <= prod_nx;
`endif
        default: ;
      endcase
    end
  end

  // Store commits at the end of EXEC; suppressed by reset.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_EXEC && is_store && !ill_now)
      dmem_q[widx] <= b;
  end

  // Register file: cleared on reset, written at the end of WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (state_q == S_WB && wb_q) begin
      regs_q[rd_q[RW-1:0]] <= data_q;
    end
  end

endmodule

// File: tb/tb_exec_unit_mc.sv
// tb_exec_unit_mc: directed + random instructions vs. a behavioural model.
// Honours EXEC_MUL_EN the same way as the design.
module tb_exec_unit_mc;
  logic        clk = 1'b0;
  logic        rst, instr_valid, instr_ready;
  logic [31:0] instr, result_data;
  logic        result_valid, result_wb, illegal, halted;
  logic [4:0]  result_rd;

  always #5 clk = ~clk;

  exec_unit_mc dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr),
    .result_valid(result_valid), .result_data(result_data),
    .result_rd(result_rd), .result_wb(result_wb),
    .illegal(illegal), .halted(halted)
  );

`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_XOR = 4;
  localparam int K_SLT = 5, K_SLTU = 6, K_SLL = 7, K_SRL = 8, K_SRA = 9;
  localparam int K_ADDI = 10, K_ANDI = 11, K_ORI = 12, K_XORI = 13;
  localparam int K_SLTI = 14, K_SLLI = 15, K_SRLI = 16, K_SRAI = 17;
  localparam int K_LUI = 18, K_LW = 19, K_SW = 20, K_ILL = 21;
  localparam int K_MUL = 22, K_ECALL = 23;
  localparam int LIM = 100;

  int n_chk = 0, n_pass = 0;
  logic [31:0] mregs [32];
  logic [31:0] mmem [256];
  logic [31:0] last_d;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] r_t(input logic [6:0] f7,
      input logic [4:0] rs2, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_t(input logic [11:0] imm,
      input logic [4:0] rs1, input logic [2:0] f3,
      input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_t(input logic [11:0] imm,
      input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] encode(input int k,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm, input int v);
    logic [6:0] oi;
    oi = 7'b0010011;
    case (k)
      K_ADD:  return r_t(7'h00, rs2, rs1, 3'b000, rd);
      K_SUB:  return r_t(7'h20, rs2, rs1, 3'b000, rd);
      K_AND:  return r_t(7'h00, rs2, rs1, 3'b111, rd);
      K_OR:   return r_t(7'h00, rs2, rs1, 3'b110, rd);
      K_XOR:  return r_t(7'h00, rs2, rs1, 3'b100, rd);
      K_SLT:  return r_t(7'h00, rs2, rs1, 3'b010, rd);
      K_SLTU: return r_t(7'h00, rs2, rs1, 3'b011, rd);
      K_SLL:  return r_t(7'h00, rs2, rs1, 3'b001, rd);
      K_SRL:  return r_t(7'h00, rs2, rs1, 3'b101, rd);
      K_SRA:  return r_t(7'h20, rs2, rs1, 3'b101, rd);
      K_MUL:  return r_t(7'h01, rs2, rs1, 3'b000, rd);
      K_ADDI: return i_t(imm[11:0], rs1, 3'b000, rd, oi);
      K_ANDI: return i_t(imm[11:0], rs1, 3'b111, rd, oi);
      K_ORI:  return i_t(imm[11:0], rs1, 3'b110, rd, oi);
      K_XORI: return i_t(imm[11:0], rs1, 3'b100, rd, oi);
      K_SLTI: return i_t(imm[11:0], rs1, 3'b010, rd, oi);
      K_SLLI: return i_t({7'h00, imm[4:0]}, rs1, 3'b001, rd, oi);
      K_SRLI: return i_t({7'h00, imm[4:0]}, rs1, 3'b101, rd, oi);
      K_SRAI: return i_t({7'h20, imm[4:0]}, rs1, 3'b101, rd, oi);
      K_LUI:  return {imm[19:0], rd, 7'b0110111};
      K_LW:   return i_t(imm[11:0], rs1, 3'b010, rd, 7'b0000011);
      K_SW:   return s_t(imm[11:0], rs2, rs1, 3'b010);
      K_ECALL: return 32'h0000_0073;
      default: begin
        case (v)
          0: return i_t(imm[11:0], rs1, 3'b011, rd, oi);
          1: return r_t(7'h02, rs2, rs1, 3'b000, rd);
          2: return {imm[19:0], rd, 7'b1101111};
          3: return i_t(imm[11:0], rs1, 3'b000, rd, 7'b0000011);
          4: return i_t({7'h20, imm[4:0]}, rs1, 3'b001, rd, oi);
          default: return s_t(imm[11:0], rs2, rs1, 3'b000);
        endcase
      end
    endcase
  endfunction

  // Architectural effect of one instruction on the model state.
  task automatic predict(input int k, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
      output logic [31:0] d, output bit wb, output bit ill,
      output int lat, output bit cd);
    logic [31:0] a, b, ie, ad;
    a = mregs[rs1];
    b = mregs[rs2];
    ie = {{20{imm[11]}}, imm[11:0]};
    ill = 0; lat = 2; cd = 1; wb = (rd != 0); d = 0;
    case (k)
      K_ADD:  d = a + b;
      K_SUB:  d = a - b;
      K_AND:  d = a & b;
      K_OR:   d = a | b;
      K_XOR:  d = a ^ b;
      K_SLT:  d = ($signed(a) < $signed(b)) ? 1 : 0;
      K_SLTU: d = (a < b) ? 1 : 0;
      K_SLL:  d = a << b[4:0];
      K_SRL:  d = a >> b[4:0];
      K_SRA:  d = $signed(a) >>> b[4:0];
      K_ADDI: d = a + ie;
      K_ANDI: d = a & ie;
      K_ORI:  d = a | ie;
      K_XORI: d = a ^ ie;
      K_SLTI: d = ($signed(a) < $signed(ie)) ? 1 : 0;
      K_SLLI: d = a << imm[4:0];
      K_SRLI: d = a >> imm[4:0];
      K_SRAI: d = $signed(a) >>> imm[4:0];
      K_LUI:  d = {imm[19:0], 12'b0};
      K_MUL: begin
        if (MUL_EN) begin d = a * b; lat = 34; end
        else ill = 1;
      end
      K_LW, K_SW: begin
        ad = a + ie;
        if (ad % 4 != 0) ill = 1;
        else if (k == K_LW) begin
          d = mmem[(ad / 4) % 256];
          lat = 3;
        end else begin
          d = ad;
          wb = 0;
          mmem[(ad / 4) % 256] = b;
        end
      end
      K_ECALL: wb = 0;
      default: ill = 1;
    endcase
    if (ill) begin wb = 0; cd = 0; end
    if (wb) mregs[rd] = d;
  endtask

  // Wait for ready (bounded), offer ins, return at negedge after accept.
  task automatic accept(input logic [31:0] ins, output bit ok);
    int n;
    n = 0;
    ok = 1;
    @(negedge clk);
    while (!instr_ready && n < 50) begin @(negedge clk); n++; end
    if (!instr_ready) begin ok = 0; return; end
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, output int lat);
    bit ok;
    accept(ins, ok);
    if (!ok) begin lat = -1; return; end
    lat = 1;
    while (!result_valid && lat < LIM) begin @(negedge clk); lat++; end
  endtask

  task automatic do_op(input string tag, input int k, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm, input int v);
    logic [31:0] ins, ed;
    bit ewb, eill, cd;
    int elat, lat;
    ins = encode(k, rd, rs1, rs2, imm, v);
    predict(k, rd, rs1, rs2, imm, ed, ewb, eill, elat, cd);
    issue(ins, lat);
    check({tag, "_lat"}, lat, elat);
    if (lat > 0 && lat < LIM) begin
      check({tag, "_ill"}, illegal, eill);
      check({tag, "_wb"}, result_wb, ewb);
      if (cd) check({tag, "_data"}, result_data, ed);
      if (!eill && k != K_SW && k != K_ECALL)
        check({tag, "_rd"}, result_rd, rd);
    end
    last_d = result_data;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst = 1'b1;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    foreach (mregs[i]) mregs[i] = '0;
  endtask

  initial begin
    int bad, k, v;
    bit ok;
    logic [4:0] rd, r1, r2;
    logic [31:0] imm;
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    foreach (mregs[i]) mregs[i] = '0;
    foreach (mmem[i]) mmem[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", instr_ready, 1);
    check("rst_rv", result_valid, 0);
    check("rst_ill", illegal, 0);
    check("rst_halt", halted, 0);
    check("rst_data", result_data, 0);
    check("rst_rd", result_rd, 0);
    check("rst_wb", result_wb, 0);

    for (int w = 0; w < 256; w++) do_op("clr", K_SW, 0, 0, 0, w * 4, 0);

    do_op("addi1", K_ADDI, 1, 0, 0, 5, 0);
    do_op("addi2", K_ADDI, 2, 0, 0, -3, 0);
    do_op("add3", K_ADD, 3, 1, 2, 0, 0);
    check("add3_raw", last_d, 2);
    do_op("addi_x0", K_ADDI, 0, 0, 0, 7, 0);
    do_op("add_x0", K_ADD, 4, 0, 0, 0, 0);
    check("add_x0_raw", last_d, 0);
    do_op("x5", K_ADDI, 5, 0, 0, 32'h40, 0);
    do_op("lui6", K_LUI, 6, 0, 0, 32'hE, 0);
    do_op("x6", K_ADDI, 6, 6, 0, -339, 0);
    do_op("sw", K_SW, 0, 5, 6, 8, 0);
    check("sw_raw", last_d, 32'h48);
    do_op("lw", K_LW, 7, 5, 0, 8, 0);
    check("lw_raw", last_d, 32'hDEAD);
    do_op("lw_mis", K_LW, 8, 0, 0, 2, 0);
    do_op("rd_x8", K_ADD, 11, 8, 0, 0, 0);
    do_op("x1", K_ADDI, 1, 0, 0, 1, 0);
    do_op("sub9", K_SUB, 9, 0, 1, 0, 0);
    check("sub9_raw", last_d, 32'hFFFF_FFFF);
    do_op("m1", K_ADDI, 1, 0, 0, 7, 0);
    do_op("m2", K_ADDI, 2, 0, 0, 6, 0);
    do_op("mul", K_MUL, 3, 1, 2, 0, 0);
    if (MUL_EN) check("mul_raw", last_d, 42);
    else check("mul_ill", illegal, 1);

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 21);
      rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
      imm = $urandom;
      v = $urandom_range(0, 5);
      if ((k == K_LW || k == K_SW) && $urandom_range(0, 1) == 1) begin
        r1 = 0;
        imm = imm & 32'hFFC;
      end
      do_op("rnd", k, rd, r1, r2, imm, v);
    end

    // Reset during EXEC of a store: memory must keep its old word.
    do_op("pre13", K_ADDI, 13, 0, 0, 32'h123, 0);
    do_op("pre_sw", K_SW, 0, 0, 13, 12, 0);
    do_op("pre14", K_ADDI, 14, 0, 0, 32'h77, 0);
    accept(encode(K_SW, 0, 0, 14, 12, 0), ok);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    foreach (mregs[i]) mregs[i] = '0;
    check("rx_rv", result_valid, 0);
    check("rx_ready", instr_ready, 1);
    do_op("rx_lw", K_LW, 15, 0, 0, 12, 0);
    check("rx_lw_raw", last_d, 32'h123);

    // Reset during MEM of a load: no retirement, IDLE next cycle.
    accept(encode(K_LW, 10, 0, 0, 12, 0), ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    foreach (mregs[i]) mregs[i] = '0;
    check("rm_rv", result_valid, 0);
    check("rm_ready", instr_ready, 1);
    bad = 0;
    repeat (4) begin @(negedge clk); if (result_valid) bad++; end
    check("rm_quiet", bad, 0);
    do_op("rm_x10", K_ADD, 12, 10, 0, 0, 0);
    check("rm_x10_raw", last_d, 0);

    // ECALL halts; instr offers are ignored until reset.
    do_op("pre1", K_ADDI, 1, 0, 0, 99, 0);
    do_op("ecall", K_ECALL, 0, 0, 0, 0, 0);
    check("ecall_halt", halted, 1);
    instr = encode(K_ADDI, 1, 0, 0, 1, 0);
    instr_valid = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (instr_ready || !halted || result_valid) bad++;
    end
    instr_valid = 1'b0;
    check("halt_hold", bad, 0);
    hard_reset();
    check("hr_halt", halted, 0);
    check("hr_ready", instr_ready, 1);
    for (int r = 1; r < 32; r++) do_op("hr_reg", K_ADD, 5'(r), 5'(r), 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
